trigger_sequencer: RTL and testbench

Burst/repetition trigger scheduler for the pulser bank. It issues a programmable number of single-cycle triggers at a fixed clock period into the pulser trigger path, sitting in parallel with the button and soft triggers. Before each shot it checks the bank's aggregated busy flag, and it flags overruns when the bank is still running at the scheduled fire time. The SPI command decoder configures it and starts or aborts it.

---
 rtl/trigger_sequencer_if.sv | 36 +++
 rtl/trigger_sequencer.sv | 133 +++++++++++++
 tb/tb_trigger_sequencer.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/trigger_sequencer_if.sv
// trigger_sequencer_if: control/status bundle between the command decoder,
// the pulser bank and the trigger sequencer.
//   start, abort   - burst control from the command decoder
//   period, shots  - burst configuration, latched by the sequencer on start
//   busy           - aggregated pulser running flag
//   trigger        - one-cycle trigger pulse into the pulser trigger path
//   active, done   - burst status
//   shot_count     - triggers issued since the last accepted start
//   overrun        - sticky: a scheduled shot found the bank busy
// master: the side that drives control/configuration and observes status.
// slave:  the sequencer itself.
interface trigger_sequencer_if #(
  parameter int PER_W = 32,
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [PER_W-1:0] period;
  logic [CNT_W-1:0] shots;
  logic             busy;
  logic             trigger;
  logic             active;
  logic             done;
  logic [CNT_W-1:0] shot_count;
  logic             overrun;

  modport master (
    output start, abort, period, shots, busy,
    input  trigger, active, done, shot_count, overrun
  );

  modport slave (
    input  start, abort, period, shots, busy,
    output trigger, active, done, shot_count, overrun
  );
endinterface

// File: rtl/trigger_sequencer.sv
// trigger_sequencer: burst/repetition trigger scheduler for the pulser bank.
// Issues `shots` single-cycle triggers (0 = continuous) spaced max(period,2)
// clocks apart. Each shot waits in ARM until the bank is idle; a later shot
// that finds the bank busy sets the sticky overrun flag.
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - trigger_sequencer_if slave (control, config, busy, status)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start
// ARM   | shot scheduled; waits for busy low before firing
// FIRE  | trigger high for one cycle, shot counted
// WAIT  | counting down the remainder of the period
// DONE  | one-cycle completion pulse of a finite burst
module trigger_sequencer #(
  parameter int PER_W = 32,
  parameter int CNT_W = 16
) (
  input logic                clk,
  input logic                rst,
  trigger_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_FIRE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [PER_W-1:0] period_q, period_nx;
  logic [PER_W-1:0] cnt_q, cnt_nx;
  logic [CNT_W-1:0] shots_q, shots_nx;
  logic [CNT_W-1:0] shot_q, shot_nx, shot_inc;
  logic             first_q, first_nx;
  logic             ovr_q, ovr_nx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      period_q <= '0;
      cnt_q    <= '0;
      shots_q  <= '0;
      shot_q   <= '0;
      first_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      period_q <= period_nx;
      cnt_q    <= cnt_nx;
      shots_q  <= shots_nx;
      shot_q   <= shot_nx;
      first_q  <= first_nx;
      ovr_q    <= ovr_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    period_nx = period_q;
    cnt_nx    = cnt_q;
    shots_nx  = shots_q;
    shot_nx   = shot_q;
    first_nx  = first_q;
    ovr_nx    = ovr_q;
    shot_inc  = shot_q + CNT_W'(1);

    case (state)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          period_nx = bus.period;
          shots_nx  = bus.shots;
          shot_nx   = '0;
          ovr_nx    = 1'b0;
          first_nx  = 1'b1;
          state_nx  = S_ARM;
        end
      end
      S_ARM: begin
        if (!bus.busy) begin
          state_nx = S_FIRE;
        end else if (!first_q) begin
          ovr_nx = 1'b1;
        end
      end
      S_FIRE: begin
        shot_nx  = shot_inc;
        first_nx = 1'b0;
        if ((shots_q != '0) && (shot_inc == shots_q)) begin
          state_nx = S_DONE;
        end else if (period_q <= PER_W'(2)) begin
          // FIRE -> ARM -> FIRE already gives the 2-cycle minimum spacing
          state_nx = S_ARM;
        end else begin
          // FIRE and ARM account for two cycles, WAIT runs period-2 cycles
          state_nx = S_WAIT;
          cnt_nx   = period_q - PER_W'(3);
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_nx = S_ARM;
        end else begin
          cnt_nx = cnt_q - PER_W'(1);
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    // Abort overrides everything; the FIRE shot (already issued) still counts
    // but an aborted ARM cycle does not flag an overrun.
    if (bus.abort) begin
      state_nx = S_IDLE;
      ovr_nx   = ovr_q;
    end
  end

  assign bus.trigger    = (state == S_FIRE);
  assign bus.active     = (state == S_ARM) || (state == S_FIRE) || (state == S_WAIT);
  assign bus.done       = (state == S_DONE);
  assign bus.shot_count = shot_q;
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// tb_trigger_sequencer: self-checking bench for trigger_sequencer.
// A table of burst vectors pushes the expected trigger/done cycles into
// scoreboard queues at start; a negedge monitor pops and compares them as the
// DUT produces pulses. Hand-written sequences cover abort, start+abort,
// start-while-active, reset in FIRE and counter wrap in continuous mode
// (the wrap uses a second, 8-bit-counter instance to keep the run short).
module tb_trigger_sequencer;
  localparam int PER_W  = 32;
  localparam int CNT_W  = 16;
  localparam int CNT_W8 = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  trigger_sequencer_if #(.PER_W(PER_W), .CNT_W(CNT_W))  bus  ();
  trigger_sequencer_if #(.PER_W(PER_W), .CNT_W(CNT_W8)) bus8 ();

  trigger_sequencer #(.PER_W(PER_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  trigger_sequencer #(.PER_W(PER_W), .CNT_W(CNT_W8)) dut8 (
    .clk(clk), .rst(rst), .bus(bus8)
  );

  typedef struct {
    int period;
    int shots;
    int busy_lo;
    int busy_hi;
    int ntrig;
    int trig[4];
    int done_at;
    int cnt;
    int ovr;
  } vec_t;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  int exp_trig[$];
  int exp_done[$];
  bit mon_en  = 1'b0;
  bit prev_trig = 1'b0;
  int trig8_n = 0;
  int done8_n = 0;
  int c0;
  vec_t vecs[8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(int p, int s, int blo, int bhi, int n,
                              int t0, int t1, int t2, int t3,
                              int d, int c, int o);
    vec_t v;
    v.period = p;  v.shots = s;  v.busy_lo = blo;  v.busy_hi = bhi;
    v.ntrig = n;
    v.trig[0] = t0; v.trig[1] = t1; v.trig[2] = t2; v.trig[3] = t3;
    v.done_at = d;  v.cnt = c;  v.ovr = o;
    return v;
  endfunction

  // Scoreboard monitor for the main instance.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.trigger) begin
        if (exp_trig.size() == 0) check("unexpected_trigger", cyc, -1);
        else check("trigger_cycle", cyc, exp_trig.pop_front());
        check("active_at_trigger", bus.active, 1);
        check("trigger_back_to_back", prev_trig, 0);
      end
      if (bus.done) begin
        if (exp_done.size() == 0) check("unexpected_done", cyc, -1);
        else check("done_cycle", cyc, exp_done.pop_front());
        check("active_at_done", bus.active, 0);
      end
      prev_trig = bus.trigger;
    end
  end

  always @(negedge clk) begin
    if (bus8.trigger) trig8_n++;
    if (bus8.done) done8_n++;
  end

  task automatic run_vec(input int idx, input vec_t v);
    tick();
    c0 = cyc;
    bus.period = PER_W'(v.period);
    bus.shots  = CNT_W'(v.shots);
    for (int i = 0; i < v.ntrig; i++) exp_trig.push_back(c0 + v.trig[i]);
    exp_done.push_back(c0 + v.done_at);
    for (int k = 0; k < v.done_at + 3; k++) begin
      bus.start = (k == 0);
      bus.busy  = (k >= v.busy_lo) && (k <= v.busy_hi);
      tick();
    end
    bus.busy = 1'b0;
    check($sformatf("vec%0d_missing_trig", idx), exp_trig.size(), 0);
    check($sformatf("vec%0d_missing_done", idx), exp_done.size(), 0);
    check($sformatf("vec%0d_shot_count", idx), bus.shot_count, v.cnt);
    check($sformatf("vec%0d_overrun", idx), bus.overrun, v.ovr);
    check($sformatf("vec%0d_active", idx), bus.active, 0);
    exp_trig.delete();
    exp_done.delete();
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;  bus.abort = 1'b0;  bus.busy = 1'b0;
    bus.period = '0;   bus.shots = '0;
    bus8.start = 1'b0; bus8.abort = 1'b0; bus8.busy = 1'b0;
    bus8.period = '0;  bus8.shots = '0;

    //           per shots blo bhi n  t0  t1  t2  t3 done cnt ovr
    vecs[0] = mk(10, 3,   99, -1, 3,  2, 12, 22,  0, 23,  3, 0);
    vecs[1] = mk(0,  4,   99, -1, 4,  2,  4,  6,  8,  9,  4, 0);
    vecs[2] = mk(1,  4,   99, -1, 4,  2,  4,  6,  8,  9,  4, 0);
    vecs[3] = mk(2,  2,   99, -1, 2,  2,  4,  0,  0,  5,  2, 0);
    vecs[4] = mk(3,  3,   99, -1, 3,  2,  5,  8,  0,  9,  3, 0);
    vecs[5] = mk(4,  3,   99, -1, 3,  2,  6, 10,  0, 11,  3, 0);
    vecs[6] = mk(5,  2,    6,  8, 2,  2, 10,  0,  0, 11,  2, 1);
    vecs[7] = mk(5,  1,    1,  3, 1,  5,  0,  0,  0,  6,  1, 0);

    repeat (3) tick();
    check("rst_trigger", bus.trigger, 0);
    check("rst_active", bus.active, 0);
    check("rst_done", bus.done, 0);
    check("rst_shot_count", bus.shot_count, 0);
    check("rst_overrun", bus.overrun, 0);
    rst = 1'b0;
    tick();
    mon_en = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Abort in the WAIT cycle before ARM; overrun from this burst is kept.
    tick();
    c0 = cyc;
    bus.period = PER_W'(5);
    bus.shots  = CNT_W'(3);
    exp_trig.push_back(c0 + 2);
    exp_trig.push_back(c0 + 9);
    for (int k = 0; k < 21; k++) begin
      bus.start = (k == 0);
      bus.busy  = (k == 6) || (k == 7);
      bus.abort = (k == 12);
      tick();
    end
    bus.busy = 1'b0;
    bus.abort = 1'b0;
    check("abort_missing_trig", exp_trig.size(), 0);
    check("abort_shot_count", bus.shot_count, 2);
    check("abort_overrun_kept", bus.overrun, 1);
    check("abort_active", bus.active, 0);
    exp_trig.delete();

    // start and abort together in IDLE: not accepted, status untouched.
    bus.period = PER_W'(2);
    bus.shots  = CNT_W'(1);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (4) tick();
    check("start_abort_active", bus.active, 0);
    check("start_abort_shot_count", bus.shot_count, 2);
    check("start_abort_overrun", bus.overrun, 1);

    // start ignored while active; period/shots changes do not take effect.
    tick();
    c0 = cyc;
    bus.period = PER_W'(10);
    bus.shots  = CNT_W'(3);
    exp_trig.push_back(c0 + 2);
    exp_trig.push_back(c0 + 12);
    exp_trig.push_back(c0 + 22);
    exp_done.push_back(c0 + 23);
    for (int k = 0; k < 26; k++) begin
      bus.start = (k == 0) || (k == 5) || (k == 11) || (k == 12) || (k == 23);
      if (k == 4) begin
        bus.period = PER_W'(3);
        bus.shots  = CNT_W'(1);
      end
      tick();
    end
    bus.start = 1'b0;
    check("latch_missing_trig", exp_trig.size(), 0);
    check("latch_missing_done", exp_done.size(), 0);
    check("latch_shot_count", bus.shot_count, 3);
    check("latch_overrun_cleared", bus.overrun, 0);
    exp_trig.delete();
    exp_done.delete();

    // Reset asserted in the FIRE cycle.
    tick();
    c0 = cyc;
    bus.period = PER_W'(4);
    bus.shots  = CNT_W'(3);
    exp_trig.push_back(c0 + 2);
    for (int k = 0; k < 10; k++) begin
      bus.start = (k == 0);
      rst = (k == 2);
      if (k == 3) begin
        check("rstfire_trigger", bus.trigger, 0);
        check("rstfire_active", bus.active, 0);
        check("rstfire_done", bus.done, 0);
        check("rstfire_shot_count", bus.shot_count, 0);
        check("rstfire_overrun", bus.overrun, 0);
      end
      tick();
    end
    rst = 1'b0;
    check("rstfire_missing_trig", exp_trig.size(), 0);
    exp_trig.delete();

    // Continuous mode counter wrap on the 8-bit instance.
    tick();
    c0 = cyc;
    bus8.period = PER_W'(2);
    bus8.shots  = CNT_W8'(0);
    bus8.start  = 1'b1;
    tick();
    bus8.start = 1'b0;
    repeat (512) tick();
    check("wrap_trig_n_256", trig8_n, 256);
    check("wrap_count_zero", bus8.shot_count, 0);
    check("wrap_active", bus8.active, 1);
    repeat (2) tick();
    check("wrap_trig_n_257", trig8_n, 257);
    check("wrap_count_one", bus8.shot_count, 1);
    bus8.abort = 1'b1;
    tick();
    bus8.abort = 1'b0;
    repeat (10) tick();
    check("wrap_abort_trig_n", trig8_n, 257);
    check("wrap_no_done", done8_n, 0);
    check("wrap_abort_active", bus8.active, 0);
    check("wrap_abort_count", bus8.shot_count, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
